// File: rtl/ram_responder.sv
// RAM-side responder: backing word store exchanged as BEATS narrow bus beats, LSB beat first.
// Latency: LATENCY cycles before each access; read beats then stream for BEATS cycles; one-cycle ACK follows.
// Backpressure: write beats stall on IN_BUS_VALID=0 indefinitely; commands arriving while BUSY are ignored.
module ram_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int BUS_W   = 8,
   parameter int LATENCY = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SIG_RD,
   input  logic              SIG_WR,
   input  logic [ADDR_W-1:0] IN_ADDR,
   input  logic [BUS_W-1:0]  IN_BUS,
   input  logic              IN_BUS_VALID,
   output logic [BUS_W-1:0]  OUT_BUS,
   output logic              OUT_BUS_VALID,
   output logic              ACK,
   output logic              BUSY
);

   localparam int BEATS = DATA_W / BUS_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [LW-1:0] LAST_LAT  = LW'(LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE, WR_COLLECT, WR_WAIT, RD_WAIT, RD_SEND, DONE
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [LW-1:0]       lat_q, lat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   // Shared word register: assembles write beats, or shifts out read beats.
   logic [DATA_W-1:0]   word_q, word_d;
   logic [BUS_W-1:0]    out_bus_q, out_bus_d;
   logic                out_vld_q, out_vld_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   store [2**ADDR_W];
   logic [DATA_W-1:0]   store_rd;
   logic                store_we;

   assign store_rd = store[addr_q];

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      addr_d    = addr_q;
      word_d    = word_q;
      out_bus_d = '0;
      out_vld_d = 1'b0;
      ack_d     = 1'b0;
      store_we  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // Read wins over a simultaneous write; the write is dropped.
            if (SIG_RD) begin
               state_d = RD_WAIT;
               addr_d  = IN_ADDR;
               lat_d   = '0;
            end else if (SIG_WR) begin
               state_d = WR_COLLECT;
               addr_d  = IN_ADDR;
               beat_d  = '0;
               word_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         WR_COLLECT: begin
            if (IN_BUS_VALID) begin
               word_d[beat_q*BUS_W +: BUS_W] = IN_BUS;
               if (beat_q == LAST_BEAT) begin
                  state_d = WR_WAIT;
                  lat_d   = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         WR_WAIT: begin
            if (lat_q == LAST_LAT) begin
               store_we = 1'b1;
               state_d  = DONE;
               ack_d    = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         RD_WAIT: begin
            // Store is read on the edge entering RD_SEND; beat 0 goes out immediately.
            if (lat_q == LAST_LAT) begin
               state_d   = RD_SEND;
               beat_d    = '0;
               out_bus_d = store_rd[BUS_W-1:0];
               out_vld_d = 1'b1;
               word_d    = store_rd >> BUS_W;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         RD_SEND: begin
            if (beat_q == LAST_BEAT) begin
               state_d = DONE;
               ack_d   = 1'b1;
            end else begin
               beat_d    = beat_q + 1'b1;
               out_bus_d = word_q[BUS_W-1:0];
               out_vld_d = 1'b1;
               word_d    = word_q >> BUS_W;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   // Control and output registers; reset aborts any transaction.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         lat_q     <= '0;
         addr_q    <= '0;
         word_q    <= '0;
         out_bus_q <= '0;
         out_vld_q <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         lat_q     <= lat_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         out_bus_q <= out_bus_d;
         out_vld_q <= out_vld_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
      end
   end

   // Backing store write port; contents survive reset.
   always_ff @(posedge CLK) begin
      if (store_we) begin
         store[addr_q] <= word_q;
      end
   end

   assign OUT_BUS       = out_bus_q;
   assign OUT_BUS_VALID = out_vld_q;
   assign ACK           = ack_q;
   assign BUSY          = busy_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: table of write/read transactions plus reset and back-to-back sequences.
// Latency: checks exact cycle positions of beats and ACK for LATENCY=2, BEATS=4.
// Backpressure: exercises idle gaps between write beats and commands issued while busy.
module tb_ram_responder;

   localparam int LAT = 2;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       SIG_RD, SIG_WR;
   logic [7:0] IN_ADDR;
   logic [7:0] IN_BUS;
   logic       IN_BUS_VALID;
   logic [7:0] OUT_BUS;
   logic       OUT_BUS_VALID;
   logic       ACK;
   logic       BUSY;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;
   int exp_acks = 0;

   ram_responder #(.ADDR_W(8), .DATA_W(32), .BUS_W(8), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST_N(RST_N), .SIG_RD(SIG_RD), .SIG_WR(SIG_WR),
      .IN_ADDR(IN_ADDR), .IN_BUS(IN_BUS), .IN_BUS_VALID(IN_BUS_VALID),
      .OUT_BUS(OUT_BUS), .OUT_BUS_VALID(OUT_BUS_VALID), .ACK(ACK), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Count ACK pulses mid-cycle.
   always @(negedge CLK) begin
      if (ACK === 1'b1) ack_cnt++;
   end

   function automatic logic [31:0] pack(input logic ack, input logic busy,
                                        input logic vld, input logic [7:0] bus);
      return {21'd0, ack, busy, vld, bus};
   endfunction

   function automatic logic [31:0] obs();
      return pack(ACK, BUSY, OUT_BUS_VALID, OUT_BUS);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Starts at posedge+1 of an IDLE or DONE cycle; ends observing the DONE cycle.
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input int gap);
      logic [31:0] d;
      d = data;
      SIG_WR = 1'b1; IN_ADDR = addr;
      step();
      SIG_WR = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            IN_BUS_VALID = 1'b0;
            chk("wr_collect_stall", obs(), pack(0, 1, 0, 8'h00));
            step();
         end
         IN_BUS = d[k*8 +: 8]; IN_BUS_VALID = 1'b1;
         chk("wr_collect", obs(), pack(0, 1, 0, 8'h00));
         step();
      end
      IN_BUS_VALID = 1'b0; IN_BUS = 8'h00;
      for (int i = 0; i < LAT; i++) begin
         chk("wr_wait", obs(), pack(0, 1, 0, 8'h00));
         step();
      end
      chk("wr_ack", obs(), pack(1, 0, 0, 8'h00));
   endtask

   // mode 0: plain read; 1: SIG_WR also high at E0 with IN_BUS_VALID noise; 2: SIG_WR pulse during RD_SEND.
   task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input int mode);
      logic [31:0] e;
      e = exp;
      SIG_RD = 1'b1; IN_ADDR = addr;
      if (mode == 1) begin
         SIG_WR = 1'b1; IN_BUS = 8'h00; IN_BUS_VALID = 1'b1;
      end
      step();
      SIG_RD = 1'b0; SIG_WR = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         chk("rd_wait", obs(), pack(0, 1, 0, 8'h00));
         step();
      end
      for (int k = 0; k < 4; k++) begin
         if (mode == 2) SIG_WR = (k == 1);
         chk($sformatf("rd_beat%0d", k), obs(), pack(0, 1, 1, e[k*8 +: 8]));
         step();
      end
      SIG_WR = 1'b0; IN_BUS_VALID = 1'b0;
      chk("rd_ack", obs(), pack(1, 0, 0, 8'h00));
   endtask

   typedef struct {
      bit          is_wr;
      logic [7:0]  addr;
      logic [31:0] data;
      int          gap;
      int          mode;
      bit          idle_after;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0, 0, 1'b1};
      vecs[1] = '{1'b0, 8'h10, 32'hDEADBEEF, 0, 0, 1'b1};
      vecs[2] = '{1'b1, 8'h20, 32'h11223344, 2, 0, 1'b0};
      vecs[3] = '{1'b0, 8'h20, 32'h11223344, 0, 0, 1'b1};
      vecs[4] = '{1'b0, 8'h10, 32'hDEADBEEF, 0, 1, 1'b1};
      vecs[5] = '{1'b0, 8'h10, 32'hDEADBEEF, 0, 0, 1'b1};
      vecs[6] = '{1'b1, 8'hFF, 32'hAAAAAAAA, 0, 0, 1'b0};
      vecs[7] = '{1'b1, 8'h00, 32'h55555555, 1, 0, 1'b1};
      vecs[8] = '{1'b0, 8'hFF, 32'hAAAAAAAA, 0, 0, 1'b0};
      vecs[9] = '{1'b0, 8'h00, 32'h55555555, 0, 0, 1'b1};

      RST_N = 1'b0; SIG_RD = 1'b0; SIG_WR = 1'b0;
      IN_ADDR = 8'h00; IN_BUS = 8'h00; IN_BUS_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_outputs", obs(), pack(0, 0, 0, 8'h00));
      RST_N = 1'b1;
      step();
      chk("idle_after_reset", obs(), pack(0, 0, 0, 8'h00));

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].is_wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].gap);
         else               do_read(vecs[v].addr, vecs[v].data, vecs[v].mode);
         exp_acks++;
         @(negedge CLK);
         #1;
         chk("ack_count", ack_cnt, exp_acks);
         if (vecs[v].idle_after) begin
            step();
            chk("ack_one_cycle", obs(), pack(0, 0, 0, 8'h00));
         end
      end

      // Reset in the middle of a write after two beats: store must be untouched.
      SIG_WR = 1'b1; IN_ADDR = 8'h10;
      step();
      SIG_WR = 1'b0;
      IN_BUS = 8'h0D; IN_BUS_VALID = 1'b1;
      step();
      IN_BUS = 8'hF0;
      step();
      IN_BUS = 8'hFE;
      RST_N = 1'b0;
      #1;
      chk("rst_mid_write_outputs", obs(), pack(0, 0, 0, 8'h00));
      step();
      chk("rst_held_outputs", obs(), pack(0, 0, 0, 8'h00));
      IN_BUS_VALID = 1'b0; IN_BUS = 8'h00;
      RST_N = 1'b1;
      step();
      chk("idle_after_rst_write", obs(), pack(0, 0, 0, 8'h00));
      chk("ack_count_rst_write", ack_cnt, exp_acks);
      do_read(8'h10, 32'hDEADBEEF, 0);
      exp_acks++;
      step();

      // SIG_WR during RD_SEND ignored; SIG_RD in the DONE cycle starts the next read.
      do_read(8'h10, 32'hDEADBEEF, 2);
      exp_acks++;
      do_read(8'h20, 32'h11223344, 0);
      exp_acks++;
      step();
      chk("ack_count_b2b", ack_cnt, exp_acks);
      chk("idle_after_b2b", obs(), pack(0, 0, 0, 8'h00));

      // Reset in the middle of a read burst: truncated, no ACK.
      SIG_RD = 1'b1; IN_ADDR = 8'h20;
      step();
      SIG_RD = 1'b0;
      repeat (LAT) step();
      chk("rd_trunc_beat0", obs(), pack(0, 1, 1, 8'h44));
      step();
      chk("rd_trunc_beat1", obs(), pack(0, 1, 1, 8'h33));
      RST_N = 1'b0;
      #1;
      chk("rst_mid_read_outputs", obs(), pack(0, 0, 0, 8'h00));
      step();
      RST_N = 1'b1;
      repeat (3) step();
      chk("no_ack_after_rst_read", ack_cnt, exp_acks);
      chk("idle_after_rst_read", obs(), pack(0, 0, 0, 8'h00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
